// File: rtl/bandgap_seq_ctrl.sv
// Power-up sequencer and health monitor for N_CH bandgap channels: enables one
// channel at a time, waits a settle time, then confirms its ok comparator.
module bandgap_seq_ctrl #(
  parameter int N_CH        = 4,
  parameter int SETTLE_CYC  = 1024,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [N_CH-1:0] en_req_i,
  input  logic [N_CH-1:0] bg_ok_i,
  input  logic [N_CH-1:0] clr_fault_i,
  output logic [N_CH-1:0] bg_en_o,
  output logic [N_CH-1:0] ch_ready_o,
  output logic [N_CH-1:0] ch_fault_o,
  output logic            busy_o,
  output logic            irq_o
);

  localparam int               CUR_W        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [N_CH-1:0]  CH_ONE       = N_CH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_WAIT_OK = 2'd2
  } state_t;

  state_t           r_state;
  logic [CUR_W-1:0] r_cur;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_irq;
  logic [N_CH-1:0]  r_ok_meta;
  logic [N_CH-1:0]  r_ok_s;
  logic [N_CH-1:0]  r_en;
  logic [N_CH-1:0]  r_rdy;
  logic [N_CH-1:0]  r_flt;

  logic             w_sel_vld;
  logic [CUR_W-1:0] w_sel;
  logic             w_launch;
  logic [N_CH-1:0]  w_sel_oh;
  logic [N_CH-1:0]  w_cur_oh;
  logic             w_abort;
  logic             w_ok_cur;
  logic             w_ready_ev;
  logic             w_timeout;
  logic [N_CH-1:0]  w_brown;
  logic [N_CH-1:0]  w_fault_ev;
  logic [N_CH-1:0]  w_en_nxt;
  logic [N_CH-1:0]  w_rdy_nxt;
  logic [N_CH-1:0]  w_flt_nxt;

  // Descending scan so the lowest eligible index is the one left selected.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_req_i[i] && !r_en[i] && !r_flt[i]) begin
        w_sel_vld = 1'b1;
        w_sel     = CUR_W'(i);
      end
    end
  end

  always_comb begin
    w_launch   = (r_state == ST_IDLE) && w_sel_vld;
    w_sel_oh   = w_launch ? (CH_ONE << w_sel) : '0;
    w_cur_oh   = CH_ONE << r_cur;
    w_abort    = (r_state != ST_IDLE) && ((en_req_i & w_cur_oh) == '0);
    w_ok_cur   = (r_ok_s & w_cur_oh) != '0;
    w_ready_ev = (r_state == ST_WAIT_OK) && !w_abort && w_ok_cur;
    w_timeout  = (r_state == ST_WAIT_OK) && !w_abort && !w_ok_cur &&
                 (r_cnt == TIMEOUT_LAST);
    w_brown    = r_rdy & ~r_ok_s;
    w_fault_ev = w_brown | (w_timeout ? w_cur_oh : '0);
    // A fault event outranks a clear arriving in the same cycle.
    w_en_nxt   = (r_en | w_sel_oh) & ~w_fault_ev & en_req_i;
    w_rdy_nxt  = (r_rdy | (w_ready_ev ? w_cur_oh : '0)) & ~w_brown & en_req_i;
    w_flt_nxt  = (r_flt & ~clr_fault_i) | w_fault_ev;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_cur     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_irq     <= 1'b0;
      r_ok_meta <= '0;
      r_ok_s    <= '0;
      r_en      <= '0;
      r_rdy     <= '0;
      r_flt     <= '0;
    end else begin
      r_ok_meta <= bg_ok_i;
      r_ok_s    <= r_ok_meta;
      r_en      <= w_en_nxt;
      r_rdy     <= w_rdy_nxt;
      r_flt     <= w_flt_nxt;
      r_irq     <= |w_fault_ev;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_vld) begin
            r_cur   <= w_sel;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_abort) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_OK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_OK: begin
          // Abort, ready and timeout all end the sequence for this channel.
          if (w_abort || w_ok_cur || (r_cnt == TIMEOUT_LAST)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bg_en_o    = r_en;
  assign ch_ready_o = r_rdy;
  assign ch_fault_o = r_flt;
  assign busy_o     = r_busy;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_bandgap_seq_ctrl.sv
// Event scoreboard bench for bandgap_seq_ctrl: every output transition is
// matched, in order and by cycle number, against expectations queued at stimulus.
module tb_bandgap_seq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] en_req;
  logic [3:0] bg_ok;
  logic [3:0] clr_fault;
  logic [3:0] bg_en;
  logic [3:0] ch_ready;
  logic [3:0] ch_fault;
  logic       busy;
  logic       irq;

  bandgap_seq_ctrl #(
    .N_CH       (4),
    .SETTLE_CYC (8),
    .TIMEOUT_CYC(16),
    .CNT_W      (16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .en_req_i   (en_req),
    .bg_ok_i    (bg_ok),
    .clr_fault_i(clr_fault),
    .bg_en_o    (bg_en),
    .ch_ready_o (ch_ready),
    .ch_fault_o (ch_fault),
    .busy_o     (busy),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  prv[5];
  logic        mon_on = 1'b0;
  int          t0;
  int          e0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // kind: 0 bg_en, 1 ch_ready, 2 ch_fault, 3 irq, 4 busy
  function automatic logic [31:0] mk(input int k, input int c, input int v, input int cy);
    return {4'(k), 4'(c), 3'b000, 1'(v), 20'(cy)};
  endfunction

  function automatic void push(input int k, input int c, input int v, input int cy);
    exp_q.push_back(mk(k, c, v, cy));
  endfunction

  function automatic logic [3:0] snap(input int k);
    case (k)
      0:       return bg_en;
      1:       return ch_ready;
      2:       return ch_fault;
      3:       return {3'b000, irq};
      default: return {3'b000, busy};
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        logic [3:0] cv;
        cv = snap(k);
        if (mon_on) begin
          for (int c = 0; c < 4; c++) begin
            if (cv[c] !== prv[k][c]) begin
              if (exp_q.size() == 0)
                check("unexpected_event", mk(k, c, int'(cv[c]), cyc), 32'h0);
              else
                check("event", mk(k, c, int'(cv[c]), cyc), exp_q.pop_front());
            end
          end
        end
        prv[k] = cv;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_pending", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    en_req    = 4'b0000;
    bg_ok     = 4'b1111;
    clr_fault = 4'b0000;
    #1 rst = 1'b1;
    repeat (3) step();
    check("rst_bg_en", 32'(bg_en), 32'h0);
    check("rst_ready", 32'(ch_ready), 32'h0);
    check("rst_fault", 32'(ch_fault), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    repeat (4) step();
    mon_on = 1'b1;

    // Ascending sequencing of channels 0, 1, 3
    step();
    e0 = cyc + 1;
    push(0, 0, 1, e0);      push(4, 0, 1, e0);
    push(1, 0, 1, e0 + 9);  push(4, 0, 0, e0 + 9);
    push(0, 1, 1, e0 + 10); push(4, 0, 1, e0 + 10);
    push(1, 1, 1, e0 + 19); push(4, 0, 0, e0 + 19);
    push(0, 3, 1, e0 + 20); push(4, 0, 1, e0 + 20);
    push(1, 3, 1, e0 + 29); push(4, 0, 0, e0 + 29);
    en_req = 4'b1011;
    drain(60);
    check("seq_bg_en", 32'(bg_en), 32'hb);
    check("seq_ready", 32'(ch_ready), 32'hb);

    // Drop everything, then time out channel 1
    step();
    t0 = cyc + 1;
    push(0, 0, 0, t0); push(0, 1, 0, t0); push(0, 3, 0, t0);
    push(1, 0, 0, t0); push(1, 1, 0, t0); push(1, 3, 0, t0);
    en_req = 4'b0000;
    bg_ok  = 4'b1101;
    drain(10);
    repeat (3) step();
    e0 = cyc + 1;
    push(0, 1, 1, e0);      push(4, 0, 1, e0);
    push(0, 1, 0, e0 + 24); push(2, 1, 1, e0 + 24);
    push(3, 0, 1, e0 + 24); push(4, 0, 0, e0 + 24);
    push(3, 0, 0, e0 + 25);
    en_req = 4'b0010;
    drain(40);
    check("to_fault", 32'(ch_fault), 32'h2);
    check("to_bg_en", 32'(bg_en), 32'h0);

    // Clear restarts channel 1; clear again exactly as it times out
    step();
    t0 = cyc;
    push(2, 1, 0, t0 + 1);
    push(0, 1, 1, t0 + 2); push(4, 0, 1, t0 + 2);
    clr_fault = 4'b0010;
    step();
    clr_fault = 4'b0000;
    e0 = t0 + 2;
    wait_cyc(e0 + 23);
    push(0, 1, 0, e0 + 24); push(2, 1, 1, e0 + 24);
    push(3, 0, 1, e0 + 24); push(4, 0, 0, e0 + 24);
    push(3, 0, 0, e0 + 25);
    clr_fault = 4'b0010;
    step();
    clr_fault = 4'b0000;
    drain(10);
    check("clr_vs_fault", 32'(ch_fault[1]), 32'h1);

    step();
    push(2, 1, 0, cyc + 1);
    en_req    = 4'b0000;
    clr_fault = 4'b0010;
    step();
    clr_fault = 4'b0000;
    drain(5);

    // Brown-out on channel 0
    bg_ok = 4'b1111;
    repeat (3) step();
    e0 = cyc + 1;
    push(0, 0, 1, e0);     push(4, 0, 1, e0);
    push(1, 0, 1, e0 + 9); push(4, 0, 0, e0 + 9);
    en_req = 4'b0001;
    drain(20);
    step();
    t0 = cyc;
    push(0, 0, 0, t0 + 3); push(1, 0, 0, t0 + 3);
    push(2, 0, 1, t0 + 3); push(3, 0, 1, t0 + 3);
    push(3, 0, 0, t0 + 4);
    bg_ok = 4'b1110;
    repeat (5) step();
    bg_ok = 4'b1111;
    drain(5);
    check("bo_fault", 32'(ch_fault), 32'h1);
    check("bo_busy", 32'(busy), 32'h0);

    step();
    push(2, 0, 0, cyc + 1);
    en_req    = 4'b0000;
    clr_fault = 4'b0001;
    step();
    clr_fault = 4'b0000;
    drain(5);

    // Abort channel 2 in SETTLE, sequencer moves on to channel 3
    step();
    e0 = cyc + 1;
    push(0, 2, 1, e0); push(4, 0, 1, e0);
    en_req = 4'b1100;
    wait_cyc(e0 + 3);
    push(0, 2, 0, e0 + 4);  push(4, 0, 0, e0 + 4);
    push(0, 3, 1, e0 + 5);  push(4, 0, 1, e0 + 5);
    push(1, 3, 1, e0 + 14); push(4, 0, 0, e0 + 14);
    en_req = 4'b1000;
    drain(20);
    check("ab_fault", 32'(ch_fault), 32'h0);
    check("ab_bg_en", 32'(bg_en), 32'h8);

    // Asynchronous reset while channel 0 sits in WAIT_OK
    step();
    e0 = cyc + 1;
    push(0, 0, 1, e0); push(4, 0, 1, e0);
    en_req = 4'b1001;
    bg_ok  = 4'b1110;
    wait_cyc(e0 + 10);
    push(0, 0, 0, e0 + 10); push(0, 3, 0, e0 + 10);
    push(1, 3, 0, e0 + 10); push(4, 0, 0, e0 + 10);
    rst = 1'b1;
    #1;
    check("ar_bg_en", 32'(bg_en), 32'h0);
    check("ar_ready", 32'(ch_ready), 32'h0);
    check("ar_fault", 32'(ch_fault), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_irq", 32'(irq), 32'h0);
    @(negedge clk);
    #1;
    rst   = 1'b0;
    bg_ok = 4'b1111;
    t0 = e0 + 11;
    push(0, 0, 1, t0);      push(4, 0, 1, t0);
    push(1, 0, 1, t0 + 9);  push(4, 0, 0, t0 + 9);
    push(0, 3, 1, t0 + 10); push(4, 0, 1, t0 + 10);
    push(1, 3, 1, t0 + 19); push(4, 0, 0, t0 + 19);
    drain(40);
    check("rs_bg_en", 32'(bg_en), 32'h9);
    check("rs_ready", 32'(ch_ready), 32'h9);

    repeat (3) step();
    check("left_in_queue", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
